// File: rtl/mlp_weight_bank_if.sv
// Load-side streaming port of mlp_weight_bank: valid/ready word stream plus frame control and status pulses.
// The master side (sequencer/host) drives start/abort/valid/data; the weight bank is the slave.
interface mlp_weight_bank_if #(
  parameter int W1 = 6
);
  logic          load_start;
  logic          load_abort;
  logic          load_valid;
  logic          load_ready;
  logic [W1-1:0] load_data;
  logic          load_done;
  logic          load_err;

  modport master (
    output load_start, load_abort, load_valid, load_data,
    input  load_ready, load_done, load_err
  );

  modport slave (
    input  load_start, load_abort, load_valid, load_data,
    output load_ready, load_done, load_err
  );
endinterface

// File: rtl/mlp_weight_bank.sv
// Double-buffered, runtime-loadable weight store for the MLP denoiser: frames stream into a shadow bank and commit atomically.
// Optional MLP_WEIGHT_BANK_CHECKSUM_EN adds an XOR trailer word and a one-cycle CHECK state before COMMIT.
module mlp_weight_bank #(
  parameter int N1 = 98,
  parameter int N2 = 10,
  parameter int W1 = 6,
  parameter int W2 = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  mlp_weight_bank_if.slave                  ld,
  output logic                              weights_valid,
  output logic [N2-1:0][N1/2:0][W1-1:0]     weights_n1_mag,
  output logic [N2-1:0][N1/2:0][W1-1:0]     weights_n1_pol,
  output logic [N2:0][W2-1:0]               weights_n2
);

  localparam int HALF   = N1 / 2;
  localparam int IDXMAX = (HALF > N2) ? HALF : N2;
  localparam int IW     = $clog2(IDXMAX + 1);
  localparam int NW     = $clog2(N2 + 1);

`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;
  typedef enum logic [1:0] {SEC_MAG, SEC_POL, SEC_N2, SEC_TRL} sec_t;
  logic [W1-1:0] xsum;
`else
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  typedef enum logic [1:0] {SEC_MAG, SEC_POL, SEC_N2} sec_t;
`endif

  state_t        state, nstate;
  sec_t          sec;
  logic [NW-1:0] nrn;
  logic [IW-1:0] idx;
  logic          err;
  logic          beat, restart, last_word, n2_bad;

  logic [N2-1:0][HALF:0][W1-1:0] shadow_mag;
  logic [N2-1:0][HALF:0][W1-1:0] shadow_pol;
  logic [N2:0][W2-1:0]           shadow_n2;

  // load_start outranks both a same-cycle data beat and a same-cycle abort
  assign restart = ld.load_start && (state == IDLE || state == LOAD);
  assign beat    = (state == LOAD) && ld.load_valid && !ld.load_start && !ld.load_abort;
  assign n2_bad  = !((&ld.load_data[W1-1:W2-1]) || !(|ld.load_data[W1-1:W2-1]));
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
  assign last_word = (sec == SEC_TRL);
`else
  assign last_word = (sec == SEC_N2) && (idx == IW'(N2));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (ld.load_start) nstate = LOAD;
      LOAD: begin
        if (ld.load_start)           nstate = LOAD;
        else if (ld.load_abort)      nstate = IDLE;
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
        else if (beat && last_word)  nstate = CHECK;
`else
        else if (beat && last_word)  nstate = COMMIT;
`endif
      end
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
      CHECK:   nstate = COMMIT;
`endif
      COMMIT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    ld.load_ready = (state == LOAD);
  end

  // Shadow fill: section/neuron/index counters walk mag, pol, n2 (and trailer) in frame order
  always_ff @(posedge clk) begin
    if (rst) begin
      sec        <= SEC_MAG;
      nrn        <= '0;
      idx        <= '0;
      err        <= 1'b0;
      shadow_mag <= '0;
      shadow_pol <= '0;
      shadow_n2  <= '0;
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
      xsum       <= '0;
`endif
    end else if (restart) begin
      sec <= SEC_MAG;
      nrn <= '0;
      idx <= '0;
      err <= 1'b0;
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
      xsum <= '0;
`endif
    end else if (beat) begin
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
      xsum <= xsum ^ ld.load_data;
`endif
      case (sec)
        SEC_MAG, SEC_POL: begin
          if (sec == SEC_MAG) shadow_mag[nrn][idx] <= ld.load_data;
          else                shadow_pol[nrn][idx] <= ld.load_data;
          if (idx == IW'(HALF)) begin
            idx <= '0;
            if (nrn == NW'(N2 - 1)) begin
              nrn <= '0;
              sec <= (sec == SEC_MAG) ? SEC_POL : SEC_N2;
            end else begin
              nrn <= nrn + NW'(1);
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
        SEC_N2: begin
          shadow_n2[idx] <= ld.load_data[W2-1:0];
          if (n2_bad) err <= 1'b1;
          idx <= idx + IW'(1);
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
          if (idx == IW'(N2)) sec <= SEC_TRL;
`endif
        end
        default: ;
      endcase
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
    end else if (state == CHECK) begin
      if (xsum != '0) err <= 1'b1;
`endif
    end
  end

  // Active bank only changes on a clean commit, so the outputs never see a partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      weights_n1_mag <= '0;
      weights_n1_pol <= '0;
      weights_n2     <= '0;
      weights_valid  <= 1'b0;
      ld.load_done   <= 1'b0;
      ld.load_err    <= 1'b0;
    end else begin
      ld.load_done <= 1'b0;
      ld.load_err  <= 1'b0;
      if (state == COMMIT) begin
        if (!err) begin
          weights_n1_mag <= shadow_mag;
          weights_n1_pol <= shadow_pol;
          weights_n2     <= shadow_n2;
          weights_valid  <= 1'b1;
          ld.load_done   <= 1'b1;
        end else begin
          ld.load_err    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mlp_weight_bank.sv
// Directed bench for mlp_weight_bank: frame load/commit, gaps, range error, abort, reset, restart, optional checksum.
// Frames: kind 0 = A ((i mod 8)-4), 1 = A with n2[0]=12, 2 = C (((3i+1) mod 8)-4), 3 = A with a corrupted trailer.
module tb_mlp_weight_bank;
  localparam int N1   = 98;
  localparam int N2   = 10;
  localparam int W1   = 6;
  localparam int W2   = 4;
  localparam int HALF = N1 / 2;
  localparam int NE   = HALF + 1;
  localparam int F    = 2 * N2 * NE + N2 + 1;
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
  localparam int FTOT = F + 1;
  localparam int LAT  = 2;
`else
  localparam int FTOT = F;
  localparam int LAT  = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic weights_valid;
  logic [N2-1:0][HALF:0][W1-1:0] weights_n1_mag;
  logic [N2-1:0][HALF:0][W1-1:0] weights_n1_pol;
  logic [N2:0][W2-1:0]           weights_n2;

  int    checks = 0;
  int    errors = 0;
  string diff_msg;

  always #5 clk = ~clk;

  mlp_weight_bank_if #(.W1(W1)) ld();

  mlp_weight_bank #(.N1(N1), .N2(N2), .W1(W1), .W2(W2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld             (ld.slave),
    .weights_valid  (weights_valid),
    .weights_n1_mag (weights_n1_mag),
    .weights_n1_pol (weights_n1_pol),
    .weights_n2     (weights_n2)
  );

  // Trailer values are the hand-computed XOR of each frame (full 8-word periods cancel)
  function automatic logic [W1-1:0] word(input int kind, input int i);
    int v;
    if (i == F) begin
      case (kind)
        0:       return 6'h3F;
        1:       return 6'h0F;
        2:       return 6'h3E;
        default: return 6'h3E;
      endcase
    end
    if (kind == 2) v = ((3 * i + 1) % 8) - 4;
    else           v = (i % 8) - 4;
    if (kind == 1 && i == 2 * N2 * NE) v = 12;
    return W1'(v);
  endfunction

  function automatic int bank_diffs(input int kind);
    int d = 0;
    logic [W1-1:0] e;
    for (int n = 0; n < N2; n++) begin
      for (int j = 0; j < NE; j++) begin
        e = (kind < 0) ? '0 : word(kind, n * NE + j);
        if (weights_n1_mag[n][j] !== e) begin
          if (d == 0) diff_msg = $sformatf("mag[%0d][%0d] got %h want %h", n, j, weights_n1_mag[n][j], e);
          d++;
        end
        e = (kind < 0) ? '0 : word(kind, N2 * NE + n * NE + j);
        if (weights_n1_pol[n][j] !== e) begin
          if (d == 0) diff_msg = $sformatf("pol[%0d][%0d] got %h want %h", n, j, weights_n1_pol[n][j], e);
          d++;
        end
      end
    end
    for (int k = 0; k <= N2; k++) begin
      e = (kind < 0) ? '0 : word(kind, 2 * N2 * NE + k);
      if (weights_n2[k] !== e[W2-1:0]) begin
        if (d == 0) diff_msg = $sformatf("n2[%0d] got %h want %h", k, weights_n2[k], e[W2-1:0]);
        d++;
      end
    end
    return d;
  endfunction

  // Start cycle also carries a junk beat (and optionally an abort); returns at the negedge after the last accepted beat
  task automatic applyStimulus(input int kind, input bit gaps, input int stop_at,
                               input bit abort_with_start, input bit extra_valid, output int accepted);
    int n, cyc;
    bit acc;
    n = (stop_at >= 0) ? stop_at : FTOT;
    @(negedge clk);
    ld.load_start = 1'b1;
    ld.load_abort = abort_with_start;
    ld.load_valid = 1'b1;
    ld.load_data  = 6'h15;
    @(negedge clk);
    ld.load_start = 1'b0;
    ld.load_abort = 1'b0;
    accepted = 0;
    cyc = 0;
    while (accepted < n && cyc < 4 * FTOT) begin
      ld.load_valid = !(gaps && $urandom_range(0, 3) == 0);
      ld.load_data  = word(kind, accepted);
      acc = ld.load_valid && ld.load_ready;
      @(negedge clk);
      cyc++;
      if (acc) accepted++;
    end
    ld.load_valid = extra_valid;
    ld.load_data  = 6'h2A;
  endtask

  task automatic watch_pulses(input int ncyc, output int done_cnt, output int done_at,
                              output int err_cnt, output int err_at);
    done_cnt = 0; done_at = -1; err_cnt = 0; err_at = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (ld.load_done === 1'b1) begin done_cnt++; done_at = c; end
      if (ld.load_err === 1'b1)  begin err_cnt++;  err_at = c; end
    end
  endtask

  task automatic test_reset();
    int d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (weights_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", weights_valid); end
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ld.load_ready); end
    checks++; if (ld.load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", ld.load_done); end
    checks++; if (ld.load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", ld.load_err); end
    d = bank_diffs(-1);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL reset_bank: %0d entries differ, first %s", d, diff_msg); end
  endtask

  task automatic test_full_frame();
    int acc, dc, da, ec, ea, d;
    applyStimulus(0, 1'b0, -1, 1'b0, 1'b0, acc);
    checks++; if (acc !== FTOT) begin errors++; $display("[TB] FAIL full_accepted: got %0d expected %0d", acc, FTOT); end
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_after_last: got %b expected 0", ld.load_ready); end
    watch_pulses(6, dc, da, ec, ea);
    checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL full_done_count: got %0d expected 1", dc); end
    checks++; if (da !== LAT) begin errors++; $display("[TB] FAIL full_done_latency: got %0d expected %0d", da, LAT); end
    checks++; if (ec !== 0) begin errors++; $display("[TB] FAIL full_err_count: got %0d expected 0", ec); end
    checks++; if (weights_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_valid: got %b expected 1", weights_valid); end
    d = bank_diffs(0);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL full_bank: %0d entries differ, first %s", d, diff_msg); end
    checks++; if (weights_n1_mag[0][0] !== 6'h3C) begin errors++; $display("[TB] FAIL mag_0_0: got %h expected 3c", weights_n1_mag[0][0]); end
    checks++; if (weights_n1_mag[9][49] !== 6'h3F) begin errors++; $display("[TB] FAIL mag_9_49: got %h expected 3f", weights_n1_mag[9][49]); end
    checks++; if (weights_n1_pol[0][0] !== 6'h00) begin errors++; $display("[TB] FAIL pol_0_0: got %h expected 00", weights_n1_pol[0][0]); end
    checks++; if (weights_n1_pol[9][49] !== 6'h03) begin errors++; $display("[TB] FAIL pol_9_49: got %h expected 03", weights_n1_pol[9][49]); end
    checks++; if (weights_n2[0] !== 4'hC) begin errors++; $display("[TB] FAIL n2_0: got %h expected c", weights_n2[0]); end
    checks++; if (weights_n2[10] !== 4'hE) begin errors++; $display("[TB] FAIL n2_10: got %h expected e", weights_n2[10]); end
  endtask

  task automatic test_gaps();
    int acc, dc, da, ec, ea, d;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b1, -1, 1'b0, 1'b1, acc);
    checks++; if (acc !== FTOT) begin errors++; $display("[TB] FAIL gaps_accepted: got %0d expected %0d", acc, FTOT); end
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL gaps_extra_ready: got %b expected 0", ld.load_ready); end
    watch_pulses(6, dc, da, ec, ea);
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL gaps_idle_ready: got %b expected 0", ld.load_ready); end
    ld.load_valid = 1'b0;
    checks++; if (dc !== 1 || da !== LAT) begin errors++; $display("[TB] FAIL gaps_done: got count %0d at %0d expected 1 at %0d", dc, da, LAT); end
    d = bank_diffs(0);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL gaps_bank: %0d entries differ, first %s", d, diff_msg); end
  endtask

  task automatic test_range_error();
    int acc, dc, da, ec, ea, d;
    applyStimulus(1, 1'b0, -1, 1'b0, 1'b0, acc);
    watch_pulses(6, dc, da, ec, ea);
    checks++; if (ec !== 1 || ea !== LAT) begin errors++; $display("[TB] FAIL range_err: got count %0d at %0d expected 1 at %0d", ec, ea, LAT); end
    checks++; if (dc !== 0) begin errors++; $display("[TB] FAIL range_no_done: got %0d expected 0", dc); end
    checks++; if (weights_valid !== 1'b1) begin errors++; $display("[TB] FAIL range_valid: got %b expected 1", weights_valid); end
    d = bank_diffs(0);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL range_bank_held: %0d entries differ, first %s", d, diff_msg); end
  endtask

  task automatic test_abort_and_reset();
    int acc, dc, da, ec, ea, d;
    applyStimulus(2, 1'b0, 500, 1'b0, 1'b0, acc);
    checks++; if (acc !== 500) begin errors++; $display("[TB] FAIL abort_accepted: got %0d expected 500", acc); end
    ld.load_abort = 1'b1;
    @(negedge clk);
    ld.load_abort = 1'b0;
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 0", ld.load_ready); end
    watch_pulses(4, dc, da, ec, ea);
    checks++; if (dc !== 0 || ec !== 0) begin errors++; $display("[TB] FAIL abort_pulses: got done %0d err %0d expected 0 0", dc, ec); end
    d = bank_diffs(0);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL abort_bank_held: %0d entries differ, first %s", d, diff_msg); end
    applyStimulus(2, 1'b1, -1, 1'b0, 1'b0, acc);
    watch_pulses(6, dc, da, ec, ea);
    checks++; if (dc !== 1 || da !== LAT) begin errors++; $display("[TB] FAIL frameC_done: got count %0d at %0d expected 1 at %0d", dc, da, LAT); end
    d = bank_diffs(2);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL frameC_bank: %0d entries differ, first %s", d, diff_msg); end
    checks++; if (weights_n2[10] !== 4'h3) begin errors++; $display("[TB] FAIL frameC_n2_10: got %h expected 3", weights_n2[10]); end
    applyStimulus(0, 1'b0, 300, 1'b0, 1'b0, acc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (weights_valid !== 1'b0) begin errors++; $display("[TB] FAIL midload_reset_valid: got %b expected 0", weights_valid); end
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL midload_reset_ready: got %b expected 0", ld.load_ready); end
    d = bank_diffs(-1);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL midload_reset_bank: %0d entries differ, first %s", d, diff_msg); end
  endtask

  task automatic test_restart();
    int acc, dc, da, ec, ea, d;
    applyStimulus(2, 1'b0, 200, 1'b0, 1'b0, acc);
    applyStimulus(0, 1'b0, -1, 1'b1, 1'b0, acc);
    checks++; if (acc !== FTOT) begin errors++; $display("[TB] FAIL restart_accepted: got %0d expected %0d", acc, FTOT); end
    watch_pulses(6, dc, da, ec, ea);
    checks++; if (dc !== 1 || da !== LAT) begin errors++; $display("[TB] FAIL restart_done: got count %0d at %0d expected 1 at %0d", dc, da, LAT); end
    d = bank_diffs(0);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL restart_bank: %0d entries differ, first %s", d, diff_msg); end
  endtask

`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
  task automatic test_checksum();
    int acc, dc, da, ec, ea, d;
    applyStimulus(2, 1'b0, -1, 1'b0, 1'b0, acc);
    watch_pulses(6, dc, da, ec, ea);
    checks++; if (dc !== 1 || da !== 2) begin errors++; $display("[TB] FAIL csum_good_done: got count %0d at %0d expected 1 at 2", dc, da); end
    d = bank_diffs(2);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL csum_good_bank: %0d entries differ, first %s", d, diff_msg); end
    applyStimulus(3, 1'b0, -1, 1'b0, 1'b0, acc);
    watch_pulses(6, dc, da, ec, ea);
    checks++; if (ec !== 1 || dc !== 0) begin errors++; $display("[TB] FAIL csum_bad: got err %0d done %0d expected 1 0", ec, dc); end
    d = bank_diffs(2);
    checks++; if (d !== 0) begin errors++; $display("[TB] FAIL csum_bad_bank_held: %0d entries differ, first %s", d, diff_msg); end
  endtask
`endif

  initial begin
    rst           = 1'b1;
    ld.load_start = 1'b0;
    ld.load_abort = 1'b0;
    ld.load_valid = 1'b0;
    ld.load_data  = '0;
    test_reset();
    test_full_frame();
    test_gaps();
    test_range_error();
    test_abort_and_reset();
    test_restart();
`ifdef MLP_WEIGHT_BANK_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
